// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch front-end: streams IMEM words into a 2-entry buffer, redirectable, halts on misaligned target.
// Latency 2 cycles issue-to-valid; o_instr_valid/i_instr_ready backpressure throttles issue so the buffer never overflows.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_instr_ready,
    output logic        o_imem_rden,
    output logic [13:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    output logic        o_misalign_err
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_tag_pc;
    logic        r_inflight;
    logic [1:0]  r_count;
    logic [31:0] r_instr0, r_pc0;
    logic [31:0] r_instr1, r_pc1;
    logic        r_err;

    logic        w_pop;
    logic        w_push;
    logic        w_redir;
    logic        w_issue;
    logic [1:0]  w_occ;

    // Occupancy seen by a new issue: what stays after this cycle's pop plus the response still on its way.
    assign w_pop   = (r_count != 2'd0) && i_instr_ready;
    assign w_redir = i_redirect && (r_state != HALT);
    assign w_push  = r_inflight && !i_redirect;
    assign w_occ   = r_count - {1'b0, w_pop} + {1'b0, r_inflight};
    assign w_issue = (r_state == RUN) && !i_redirect && (w_occ < 2'd2);

    assign o_imem_rden    = w_issue;
    assign o_imem_addr    = r_fetch_pc[15:2];
    assign o_instr        = r_instr0;
    assign o_instr_pc     = r_pc0;
    assign o_instr_valid  = (r_count != 2'd0);
    assign o_misalign_err = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= START_PC;
            r_tag_pc   <= 32'd0;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_instr0   <= 32'd0;
            r_pc0      <= 32'd0;
            r_instr1   <= 32'd0;
            r_pc1      <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_state <= RUN;
            end
            if (w_redir) begin
                r_count    <= 2'd0;
                r_inflight <= 1'b0;
                r_fetch_pc <= i_redirect_pc;
                if (i_redirect_pc[1:0] != 2'b00) begin
                    r_state <= HALT;
                    r_err   <= 1'b1;
                end else begin
                    r_state <= RUN;
                end
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_tag_pc   <= r_fetch_pc;
                end
                // Head is freed before the returning word lands at the tail.
                if (w_pop && w_push) begin
                    if (r_count == 2'd2) begin
                        r_instr0 <= r_instr1;
                        r_pc0    <= r_pc1;
                        r_instr1 <= i_imem_data;
                        r_pc1    <= r_tag_pc;
                    end else begin
                        r_instr0 <= i_imem_data;
                        r_pc0    <= r_tag_pc;
                    end
                end else if (w_pop) begin
                    r_instr0 <= r_instr1;
                    r_pc0    <= r_pc1;
                    r_count  <= r_count - 2'd1;
                end else if (w_push) begin
                    if (r_count == 2'd0) begin
                        r_instr0 <= i_imem_data;
                        r_pc0    <= r_tag_pc;
                    end else begin
                        r_instr1 <= i_imem_data;
                        r_pc1    <= r_tag_pc;
                    end
                    r_count <= r_count + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: queue-based reference model checked every cycle, plus directed literal checks.
// Synchronous IMEM model returns mem[addr] one cycle after each read-enable edge.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        ready = 1'b0;
    logic        rden;
    logic [13:0] addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        valid;
    logic        err;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem [0:16383];

    imem_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_redirect     (redirect),
        .i_redirect_pc  (redirect_pc),
        .i_instr_ready  (ready),
        .o_imem_rden    (rden),
        .o_imem_addr    (addr),
        .i_imem_data    (imem_data),
        .o_instr        (instr),
        .o_instr_pc     (instr_pc),
        .o_instr_valid  (valid),
        .o_misalign_err (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rden) imem_data <= mem[addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return mem[pc[15:2]];
    endfunction

    // Reference model: state as small ints, buffer as a queue of pcs, one pending read.
    int          m_state;
    logic [31:0] m_fpc;
    logic [31:0] m_pend_pc;
    logic [31:0] m_next;
    bit          m_pend;
    bit          m_err;
    logic [31:0] m_q[$];

    always @(negedge clk) begin
        bit e_valid;
        bit e_pop;
        bit e_rden;
        int occ;
        if (!rst_n) begin
            chk("rst_rden", 32'(rden), 32'd0);
            chk("rst_addr", 32'(addr), 32'(RESET_PC[15:2]));
            chk("rst_instr", instr, 32'd0);
            chk("rst_instr_pc", instr_pc, 32'd0);
            chk("rst_valid", 32'(valid), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            m_state = 0;
            m_fpc   = {RESET_PC[31:2], 2'b00};
            m_next  = m_fpc;
            m_q.delete();
            m_pend  = 1'b0;
            m_err   = 1'b0;
        end else begin
            e_valid = (m_q.size() != 0);
            e_pop   = e_valid && ready;
            occ     = m_q.size() - (e_pop ? 1 : 0) + (m_pend ? 1 : 0);
            e_rden  = (m_state == 1) && !redirect && (occ < 2);
            chk("rden", 32'(rden), 32'(e_rden));
            chk("addr", 32'(addr), 32'(m_fpc[15:2]));
            chk("valid", 32'(valid), 32'(e_valid));
            chk("misalign_err", 32'(err), 32'(m_err));
            if (e_valid) begin
                chk("instr_pc", instr_pc, m_q[0]);
                chk("instr", instr, word_at(m_q[0]));
            end
            if (valid && ready) begin
                chk("stream_order", instr_pc, m_next);
                m_next = m_next + 32'd4;
            end
            if (e_pop) void'(m_q.pop_front());
            if (redirect && m_state != 2) begin
                m_q.delete();
                m_pend = 1'b0;
                m_fpc  = redirect_pc;
                m_next = redirect_pc;
                if (redirect_pc[1:0] != 2'b00) begin
                    m_state = 2;
                    m_err   = 1'b1;
                end else begin
                    m_state = 1;
                end
            end else begin
                if (m_pend) m_q.push_back(m_pend_pc);
                m_pend = e_rden;
                if (e_rden) begin
                    m_pend_pc = m_fpc;
                    m_fpc     = m_fpc + 32'd4;
                end
                if (m_state == 0) m_state = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            ready       = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 39) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
        end
        step();
        redirect = 1'b0;
        ready    = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        ready = 1'b1;
        #2;
        chk("por_rden", 32'(rden), 32'd0);
        chk("por_valid", 32'(valid), 32'd0);
        chk("por_addr", 32'(addr), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("start_rden_idle", 32'(rden), 32'd0);
        step(); #1;
        chk("start_rden", 32'(rden), 32'd1);
        chk("start_addr0", 32'(addr), 32'd0);
        step(); #1;
        chk("start_addr1", 32'(addr), 32'd1);
        chk("start_valid0", 32'(valid), 32'd0);
        step(); #1;
        chk("start_valid", 32'(valid), 32'd1);
        chk("start_pc0", instr_pc, 32'h0);
        chk("start_instr0", instr, mem[0]);
        step(); #1;
        chk("start_pc4", instr_pc, 32'h4);
        repeat (4) step();

        // Stall for 3 cycles while pc 0x18 is at the head.
        step(); ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rden", 32'(rden), 32'd0);
            chk("bp_valid", 32'(valid), 32'd1);
            chk("bp_pc_hold", instr_pc, 32'h18);
            if (i < 2) step();
        end
        step(); ready = 1'b1;
        #1 chk("bp_resume_rden", 32'(rden), 32'd1);
        chk("bp_resume_pc", instr_pc, 32'h18);
        step(); #1 chk("bp_next_pc", instr_pc, 32'h1C);

        step(); redirect = 1'b1; redirect_pc = 32'h100;
        #1 chk("redir_rden_t", 32'(rden), 32'd0);
        step(); redirect = 1'b0;
        #1 chk("redir_addr_t1", 32'(addr), 32'h40);
        chk("redir_rden_t1", 32'(rden), 32'd1);
        chk("redir_valid_t1", 32'(valid), 32'd0);
        step(); #1 chk("redir_valid_t2", 32'(valid), 32'd0);
        step(); #1 chk("redir_valid_t3", 32'(valid), 32'd1);
        chk("redir_pc", instr_pc, 32'h100);
        chk("redir_instr", instr, mem[64]);

        step(); redirect = 1'b1; redirect_pc = 32'h0000_FFFC;
        #1 chk("wrap_rden_t", 32'(rden), 32'd0);
        step(); redirect = 1'b0;
        #1 chk("wrap_addr_hi", 32'(addr), 32'h3FFF);
        step(); #1 chk("wrap_addr_lo", 32'(addr), 32'h0);
        step(); #1 chk("wrap_pc_hi", instr_pc, 32'h0000_FFFC);
        chk("wrap_instr_hi", instr, mem[16383]);
        step(); #1 chk("wrap_pc_lo", instr_pc, 32'h0001_0000);
        chk("wrap_instr_lo", instr, mem[0]);

        rand_phase(3000);

        // Reset between edges with a full buffer.
        repeat (3) step();
        step(); ready = 1'b0;
        repeat (2) step();
        #1 chk("full_rden", 32'(rden), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rden", 32'(rden), 32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_instr", instr, 32'd0);
        chk("mid_rst_pc", instr_pc, 32'd0);
        chk("mid_rst_addr", 32'(addr), 32'(RESET_PC[15:2]));
        @(posedge clk);
        #3 rst_n = 1'b1; ready = 1'b1;
        step(); #1 chk("post_rst_rden", 32'(rden), 32'd1);
        step();
        step(); #1 chk("post_rst_valid", 32'(valid), 32'd1);
        chk("post_rst_pc", instr_pc, RESET_PC);

        rand_phase(200);

        step(); redirect = 1'b1; redirect_pc = 32'h102;
        #1 chk("mis_rden_t", 32'(rden), 32'd0);
        step(); redirect = 1'b0;
        #1 chk("mis_err_t1", 32'(err), 32'd1);
        chk("mis_rden_t1", 32'(rden), 32'd0);
        chk("mis_valid_t1", 32'(valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(); ready = ($urandom_range(0, 1) != 0);
            #1 chk("halt_rden", 32'(rden), 32'd0);
            chk("halt_valid", 32'(valid), 32'd0);
        end
        step(); redirect = 1'b1; redirect_pc = 32'h200;
        #1 chk("halt_redir_rden", 32'(rden), 32'd0);
        step(); redirect = 1'b0;
        repeat (3) begin
            step(); #1;
            chk("halt_sticky_err", 32'(err), 32'd1);
            chk("halt_sticky_rden", 32'(rden), 32'd0);
        end
        step(); #1 rst_n = 1'b0;
        #1 chk("err_clear_rst", 32'(err), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        rand_phase(500);
        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
